// File: rtl/camera_control.sv
// camera_control: board buttons plus mode/speed -> fixed-point camera pose for the ray-marcher.
// A working pose is stepped on control ticks (with hold-to-accelerate) and copied to the
// committed outputs only on frame_start_in, so each frame renders one consistent camera.
// Optional build macro: CAMERA_POS_CLAMP_EN -- saturate position components to +/-POS_LIMIT.
module camera_control #(
    parameter int FP_WIDTH     = 32,
    parameter int FRAC_BITS    = 16,
    parameter int TICK_CYCLES  = 50000,
    parameter int SPEED_BITS   = 2,
    parameter int EPS_BITS     = 7,
    parameter int ACCEL_LEVELS = 3,
    parameter int ACCEL_TICKS  = 256,
    parameter int COS_STEP     = 65533,
    parameter int SIN_STEP     = 655,
    parameter int POS_LIMIT    = 8 * (1 << FRAC_BITS)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [3:0]            btn_in,
    input  logic [1:0]            mode_in,
    input  logic [SPEED_BITS-1:0] speed_in,
    input  logic                  frame_start_in,
    output logic [FP_WIDTH-1:0]   pos_x_out,
    output logic [FP_WIDTH-1:0]   pos_y_out,
    output logic [FP_WIDTH-1:0]   pos_z_out,
    output logic [FP_WIDTH-1:0]   dir_x_out,
    output logic [FP_WIDTH-1:0]   dir_y_out,
    output logic [FP_WIDTH-1:0]   dir_z_out,
    output logic                  pose_updated_out,
    output logic [1:0]            accel_level_out
);
    typedef logic signed [FP_WIDTH-1:0] fp_t;
    typedef struct packed { fp_t px; fp_t py; fp_t pz; fp_t dx; fp_t dy; fp_t dz; } pose_t;

    localparam int CNT_W    = $clog2(TICK_CYCLES * (2 ** SPEED_BITS));
    localparam int HOLD_MAX = ACCEL_LEVELS * ACCEL_TICKS;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam int SH_W     = $clog2(EPS_BITS + 1);
    localparam fp_t ONE_C   = fp_t'(1 << FRAC_BITS);
    localparam fp_t COS_C   = fp_t'(COS_STEP);
    localparam fp_t SIN_C   = fp_t'(SIN_STEP);
    localparam pose_t POSE_RST = '{px: fp_t'(0), py: ONE_C, pz: fp_t'(-3 * (1 << FRAC_BITS) / 2),
                                   dx: fp_t'(0), dy: fp_t'(0), dz: ONE_C};

    // The acceleration shift must stay positive and fit the 2-bit level output.
    if ((ACCEL_LEVELS >= EPS_BITS) || (ACCEL_LEVELS > 3) || (POS_LIMIT <= 0)) begin : g_bad_params
        $error("camera_control: invalid parameter set");
    end

    // Fixed-point product: full-width multiply, arithmetic shift back to FRAC_BITS.
    function automatic fp_t fmul(input fp_t a, input fp_t b);
        logic signed [2*FP_WIDTH-1:0] p;
        p = (2*FP_WIDTH)'(a) * (2*FP_WIDTH)'(b);
        p = p >>> FRAC_BITS;
        return p[FP_WIDTH-1:0];
    endfunction

    // Position add/subtract, gated by en; saturating when the clamp build is selected.
    function automatic fp_t pos_add(input fp_t a, input fp_t b, input logic en, input logic sub);
`ifdef CAMERA_POS_CLAMP_EN
        logic signed [FP_WIDTH+1:0] sum;
        logic signed [FP_WIDTH+1:0] lim;
        lim = (FP_WIDTH+2)'(POS_LIMIT);
        sum = sub ? ((FP_WIDTH+2)'(a) - (FP_WIDTH+2)'(b)) : ((FP_WIDTH+2)'(a) + (FP_WIDTH+2)'(b));
        if (!en) begin
            return a;
        end else if (sum > lim) begin
            return fp_t'(POS_LIMIT);
        end else if (sum < -lim) begin
            return fp_t'(-POS_LIMIT);
        end else begin
            return sum[FP_WIDTH-1:0];
        end
`else
        return en ? (sub ? (a - b) : (a + b)) : a;
`endif
    endfunction

    // Hold count -> acceleration level, capped at ACCEL_LEVELS.
    function automatic logic [1:0] level_of(input logic [HOLD_W-1:0] h);
        logic [HOLD_W-1:0] q;
        q = h / HOLD_W'(ACCEL_TICKS);
        if (q >= HOLD_W'(ACCEL_LEVELS)) begin
            return 2'(ACCEL_LEVELS);
        end else begin
            return 2'(q);
        end
    endfunction

    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_lim_s;
    logic              tick_s;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        mode_prev_q, mode_prev_d, lvl_s, accel_level_q, accel_level_d;
    logic [SH_W-1:0]   sh_s;
    pose_t             work_q, work_d, com_q, com_d;
    logic              pose_upd_q, pose_upd_d;
    logic              lft_s, rgt_s, fwd_s, back_s;
    fp_t               dx_s, dz_s, ndx_s, ndz_s, sdx_s, sdz_s, sndx_s, sndz_s, step_s, sin_s, latx_s, latz_s;

    // Tick generator: period TICK_CYCLES*(speed_in+1); an over-limit count wraps without a tick.
    always_comb begin
        cnt_lim_s = CNT_W'(TICK_CYCLES * (int'(speed_in) + 1) - 1);
        tick_s    = (cnt_q == cnt_lim_s);
        cnt_d     = (cnt_q >= cnt_lim_s) ? '0 : cnt_q + CNT_W'(1);
    end

    // Hold counter and acceleration level; a mode change restarts acceleration.
    always_comb begin
        mode_prev_d = mode_in;
        hold_d      = hold_q;
        if (mode_in != mode_prev_q) begin
            hold_d = '0;
        end else if (tick_s) begin
            if (|btn_in) begin
                hold_d = (hold_q == HOLD_W'(HOLD_MAX)) ? hold_q : hold_q + HOLD_W'(1);
            end else begin
                hold_d = '0;
            end
        end else begin
            hold_d = hold_q;
        end
        lvl_s         = level_of(hold_q);
        accel_level_d = level_of(hold_d);
        sh_s          = SH_W'(EPS_BITS) - SH_W'(lvl_s);
    end

    // Working-pose step on a tick; motion uses the pre-tick direction and level.
    always_comb begin
        work_d = work_q;
        lft_s  = btn_in[0] & ~btn_in[1];
        rgt_s  = btn_in[1] & ~btn_in[0];
        fwd_s  = btn_in[2] & ~btn_in[3];
        back_s = btn_in[3] & ~btn_in[2];
        dx_s   = work_q.dx;
        dz_s   = work_q.dz;
        ndx_s  = -dx_s;
        ndz_s  = -dz_s;
        sdx_s  = dx_s >>> sh_s;
        sdz_s  = dz_s >>> sh_s;
        sndx_s = ndx_s >>> sh_s;
        sndz_s = ndz_s >>> sh_s;
        step_s = ONE_C >> sh_s;
        sin_s  = lft_s ? -SIN_C : SIN_C;
        latx_s = lft_s ? sndz_s : sdz_s;
        latz_s = lft_s ? sdx_s : sndx_s;
        if (tick_s) begin
            case (mode_in)
                2'd0: begin
                    work_d.px = pos_add(work_q.px, sdx_s, fwd_s | back_s, back_s);
                    work_d.pz = pos_add(work_q.pz, sdz_s, fwd_s | back_s, back_s);
                    work_d.dx = (lft_s | rgt_s) ? (fmul(dx_s, COS_C) + fmul(dz_s, sin_s)) : dx_s;
                    work_d.dz = (lft_s | rgt_s) ? (fmul(dz_s, COS_C) - fmul(dx_s, sin_s)) : dz_s;
                end
                2'd1: begin
                    work_d.px = pos_add(work_q.px, step_s, lft_s | rgt_s, lft_s);
                    work_d.py = pos_add(work_q.py, step_s, fwd_s | back_s, back_s);
                end
                2'd2: begin
                    work_d.px = pos_add(work_q.px, step_s, lft_s | rgt_s, lft_s);
                    work_d.pz = pos_add(work_q.pz, step_s, fwd_s | back_s, back_s);
                end
                2'd3: begin
                    work_d.px = pos_add(pos_add(work_q.px, sdx_s, fwd_s | back_s, back_s),
                                        latx_s, lft_s | rgt_s, 1'b0);
                    work_d.pz = pos_add(pos_add(work_q.pz, sdz_s, fwd_s | back_s, back_s),
                                        latz_s, lft_s | rgt_s, 1'b0);
                end
                default: work_d = work_q;
            endcase
        end else begin
            work_d = work_q;
        end
    end

    // Frame-synchronous commit; flag a change against the previously committed pose.
    always_comb begin
        com_d      = frame_start_in ? work_q : com_q;
        pose_upd_d = frame_start_in && (work_q != com_q);
    end

    // State registers; asynchronous reset restores the full reset pose at once.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q         <= '0;
            hold_q        <= '0;
            mode_prev_q   <= 2'd0;
            accel_level_q <= 2'd0;
            work_q        <= POSE_RST;
            com_q         <= POSE_RST;
            pose_upd_q    <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            mode_prev_q   <= mode_prev_d;
            accel_level_q <= accel_level_d;
            work_q        <= work_d;
            com_q         <= com_d;
            pose_upd_q    <= pose_upd_d;
        end
    end

    assign pos_x_out        = com_q.px;
    assign pos_y_out        = com_q.py;
    assign pos_z_out        = com_q.pz;
    assign dir_x_out        = com_q.dx;
    assign dir_y_out        = com_q.dy;
    assign dir_z_out        = com_q.dz;
    assign pose_updated_out = pose_upd_q;
    assign accel_level_out  = accel_level_q;
endmodule

// File: tb/tb_camera_control.sv
// Directed bench for camera_control with TICK_CYCLES=4 and ACCEL_TICKS=2, so each
// 4-cycle window after reset release contains exactly one tick on its last edge.
module tb_camera_control;
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [3:0]  btn_in;
    logic [1:0]  mode_in;
    logic [1:0]  speed_in;
    logic        frame_start_in;
    logic [31:0] pos_x_out, pos_y_out, pos_z_out, dir_x_out, dir_y_out, dir_z_out;
    logic        pose_updated_out;
    logic [1:0]  accel_level_out;

    int n_tests = 0;
    int n_fail  = 0;
    int pu_cnt  = 0;

    logic [31:0] z_tab [0:7] = '{32'hFFFE8000, 32'hFFFE8200, 32'hFFFE8400, 32'hFFFE8800,
                                 32'hFFFE8C00, 32'hFFFE9400, 32'hFFFE9C00, 32'hFFFEAC00};
    logic [31:0] lvl_tab [1:8] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd0};
    logic [31:0] long_x;

    camera_control #(.TICK_CYCLES(4), .ACCEL_TICKS(2), .POS_LIMIT(32'h20000)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .btn_in(btn_in), .mode_in(mode_in),
        .speed_in(speed_in), .frame_start_in(frame_start_in),
        .pos_x_out(pos_x_out), .pos_y_out(pos_y_out), .pos_z_out(pos_z_out),
        .dir_x_out(dir_x_out), .dir_y_out(dir_y_out), .dir_z_out(dir_z_out),
        .pose_updated_out(pose_updated_out), .accel_level_out(accel_level_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_in);
        @(negedge clk_in);
        if (pose_updated_out) pu_cnt++;
    endtask

    task automatic window(input logic [3:0] b, input int fpos);
        for (int c = 1; c <= 4; c++) begin
            btn_in         = b;
            frame_start_in = (c == fpos);
            cycle();
        end
        frame_start_in = 1'b0;
        btn_in         = 4'b0000;
    endtask

    task automatic do_reset();
        rst_n_in       = 1'b0;
        btn_in         = 4'b0000;
        frame_start_in = 1'b0;
        cycle();
        cycle();
        rst_n_in = 1'b1;
        pu_cnt   = 0;
    endtask

    initial begin
        rst_n_in = 1'b0; btn_in = 4'b0000; mode_in = 2'd0; speed_in = 2'd0; frame_start_in = 1'b0;
        long_x = 32'h0;

        // Reset state
        do_reset();
        check("rst_pos_x", pos_x_out, 32'h00000000);
        check("rst_pos_y", pos_y_out, 32'h00010000);
        check("rst_pos_z", pos_z_out, 32'hFFFE8000);
        check("rst_dir_x", dir_x_out, 32'h00000000);
        check("rst_dir_y", dir_y_out, 32'h00000000);
        check("rst_dir_z", dir_z_out, 32'h00010000);
        check("rst_pulse", {31'd0, pose_updated_out}, 32'd0);
        check("rst_accel", {30'd0, accel_level_out}, 32'd0);

        // TRANS_XY: one tick of right, visible only after frame_start_in
        mode_in = 2'd1;
        window(4'b0010, 0);
        window(4'b0000, 0);
        check("txy_uncommitted", pos_x_out, 32'h00000000);
        pu_cnt = 0;
        window(4'b0000, 1);
        check("txy_commit_x", pos_x_out, 32'h00000200);
        check("txy_commit_y", pos_y_out, 32'h00010000);
        check("txy_pulse", pu_cnt, 32'd1);
        pu_cnt = 0;
        window(4'b0000, 1);
        check("txy_no_change_pulse", pu_cnt, 32'd0);

        // Asynchronous reset mid-count, no clock edge
        #2 rst_n_in = 1'b0;
        #1;
        check("async_pos_x", pos_x_out, 32'h00000000);
        check("async_pos_z", pos_z_out, 32'hFFFE8000);
        check("async_dir_z", dir_z_out, 32'h00010000);
        check("async_pulse", {31'd0, pose_updated_out}, 32'd0);

        // Acceleration in TRANS_XZ: up held 7 ticks then released one tick
        mode_in = 2'd2;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            window((i <= 7) ? 4'b0100 : 4'b0000, 1);
            check($sformatf("accel_z_%0d", i - 1), pos_z_out, z_tab[i-1]);
            check($sformatf("accel_lvl_%0d", i), {30'd0, accel_level_out}, lvl_tab[i]);
        end
        window(4'b0000, 1);
        check("accel_z_7", pos_z_out, z_tab[7]);
        check("accel_x_still", pos_x_out, 32'h00000000);

        // WALK: rotate left, left+right cancels, then walk forward on the new heading
        mode_in = 2'd0;
        do_reset();
        window(4'b0001, 0);
        window(4'b0000, 1);
        check("walk_rot_dx", dir_x_out, 32'hFFFFFD71);
        check("walk_rot_dz", dir_z_out, 32'h0000FFFD);
        check("walk_rot_dy", dir_y_out, 32'h00000000);
        check("walk_rot_px", pos_x_out, 32'h00000000);
        window(4'b0011, 0);
        window(4'b0000, 1);
        check("walk_lr_dx", dir_x_out, 32'hFFFFFD71);
        check("walk_lr_dz", dir_z_out, 32'h0000FFFD);
        window(4'b0100, 0);
        window(4'b0000, 1);
        check("walk_fwd_px", pos_x_out, 32'hFFFFFFFA);
        check("walk_fwd_pz", pos_z_out, 32'hFFFE81FF);

        // Tick coincident with frame_start_in commits the pre-tick pose
        mode_in = 2'd1;
        do_reset();
        window(4'b0010, 4);
        check("coin_pre_tick_x", pos_x_out, 32'h00000000);
        check("coin_no_pulse", pu_cnt, 32'd0);
        window(4'b0000, 1);
        check("coin_next_x", pos_x_out, 32'h00000200);
        check("coin_next_pulse", pu_cnt, 32'd1);

        // STRAFE: left then right from dir (0,0,ONE)
        mode_in = 2'd3;
        do_reset();
        window(4'b0001, 0);
        window(4'b0000, 1);
        check("strafe_l_x", pos_x_out, 32'hFFFFFE00);
        check("strafe_l_z", pos_z_out, 32'hFFFE8000);
        window(4'b0010, 0);
        window(4'b0000, 1);
        check("strafe_r_x", pos_x_out, 32'h00000000);

        // speed_in=1 doubles the tick period to 8 cycles
        mode_in  = 2'd1;
        speed_in = 2'd1;
        do_reset();
        window(4'b0010, 0);
        window(4'b0010, 1);
        check("speed1_no_early_tick", pos_x_out, 32'h00000000);
        window(4'b0000, 1);
        check("speed1_tick_x", pos_x_out, 32'h00000200);
        speed_in = 2'd0;

        // Long right hold: wraps past the clamp bound unless the clamp is built in
        do_reset();
        for (int i = 0; i < 37; i++) begin
            window(4'b0010, 0);
        end
        check("long_accel_max", {30'd0, accel_level_out}, 32'd3);
        window(4'b0000, 1);
`ifdef CAMERA_POS_CLAMP_EN
        long_x = 32'h00020000;
`else
        long_x = 32'h00020C00;
`endif
        check("long_x", pos_x_out, long_x);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/camera_control.md
Name: camera_control

Overview:
- Parametrised successor to the team's button/switch camera controller. Converts board buttons and mode/speed inputs into a fixed-point camera pose (position plus view direction) for the ray-marcher.
- Adds hold-to-accelerate stepping and a strafe mode.
- Adds frame-synchronous pose commit, so every rendered frame sees one consistent camera.
- Sits between board I/O debouncers and the render core's camera inputs.

Parameters:
FP_WIDTH, 32, signed fixed-point word width of every coordinate
FRAC_BITS, 16, fractional bits; ONE = 1 << FRAC_BITS
TICK_CYCLES, 50000, base clock cycles per control tick (1 ms at 50 MHz)
SPEED_BITS, 2, width of speed_in
EPS_BITS, 7, base step = ONE >> EPS_BITS (level 0)
ACCEL_LEVELS, 3, max acceleration level; step = ONE >> (EPS_BITS - level); must be < EPS_BITS
ACCEL_TICKS, 256, consecutive held ticks per acceleration level
COS_STEP, 65533, cos(0.01) in fixed point
SIN_STEP, 655, sin(0.01) in fixed point
POS_LIMIT, 8*ONE, clamp bound (used only with the optional feature)

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
btn_in  input  4  {down, up, right, left}, debounced, level
mode_in  input  2  0 WALK, 1 TRANS_XY, 2 TRANS_XZ, 3 STRAFE
speed_in  input  SPEED_BITS  tick period multiplier, period = TICK_CYCLES*(speed_in+1)
frame_start_in  input  1  one-cycle pulse from the renderer at frame start
pos_x_out, pos_y_out, pos_z_out  output  FP_WIDTH each  committed camera position
dir_x_out, dir_y_out, dir_z_out  output  FP_WIDTH each  committed view direction
pose_updated_out  output  1  one-cycle pulse: the committed pose changed
accel_level_out  output  2  current acceleration level

Behaviour:
- Reset (async assert, sync release): working and committed pos = (0, ONE, -3*ONE/2); dir = (0, 0, ONE); tick counter 0; hold counter 0; accel 0; pose_updated_out 0.
- Tick generator:
  - Counter increments each cycle.
  - When it reaches TICK_CYCLES*(speed_in+1)-1, it issues a one-cycle tick and wraps to 0.
  - A speed_in change takes effect at the next compare; if the counter already exceeds the new limit, it wraps on the next cycle.
- Acceleration:
  - On a tick with any direction button active, the hold counter increments, saturating at ACCEL_LEVELS*ACCEL_TICKS.
  - On a tick with no button active, or any cycle where mode_in differs from its previous-cycle value, the hold counter clears.
  - level = min(hold/ACCEL_TICKS, ACCEL_LEVELS); step = ONE >> (EPS_BITS - level).
- Working-pose update on tick only; opposing buttons pressed together cancel (no motion on that axis):
  - TRANS_XY: left/right -/+ step on x; down/up -/+ step on y.
  - TRANS_XZ: same, with z replacing y.
  - WALK:
    - up/down: pos.x,z +/- (dir.x,z >>> (EPS_BITS-level)).
    - left/right: rotate dir in the x-z plane by -/+0.01 rad: x' = x*c + z*s; z' = -x*s + z*c, with s negated for left.
    - Products are (a*b) >>> FRAC_BITS, 2*FP_WIDTH intermediate, arithmetic shift.
    - Translation and rotation use pre-tick dir values.
    - left+right together: no rotation.
  - STRAFE: up/down as WALK; left/right translate along (-dir.z, dir.x) / (dir.z, -dir.x), scaled >>> (EPS_BITS-level).
  - dir.y is never modified.
- Arithmetic without clamp: two's-complement wrap at FP_WIDTH.
- Commit:
  - On frame_start_in, committed outputs load the working pose as registered at that edge.
  - A tick in the same cycle lands in the working pose and is committed at the next frame_start_in.
  - pose_updated_out pulses the cycle after a commit whose loaded value differs from the prior committed value.
- Reset asserted mid-tick or mid-commit: everything returns to reset values immediately; no partial pose survives.

Optional Feature:
CAMERA_POS_CLAMP_EN
- Defined: each position component saturates to [-POS_LIMIT, +POS_LIMIT] after every update, with saturating add (no wrap).
- Undefined: no clamp logic; pure wrap arithmetic; POS_LIMIT is ignored.

Test Plan:
- Reset: assert rst_n_in low asynchronously mid-count -> outputs (0, 0x10000, 0xFFFE8000) and dir (0, 0, 0x10000) without a clock edge; pose_updated_out 0.
- TRANS_XY, TICK_CYCLES=4, speed 0, right held 1 tick -> working x=0x200; pos_x_out stays 0 until frame_start_in, then 0x200 with pose_updated_out pulse next cycle.
- Accel, ACCEL_TICKS=2, up held in TRANS_XZ for 7 ticks -> z increments 0x200, 0x200, 0x400, 0x400, 0x800, 0x800, 0x1000; accel_level_out reaches 3; release for 1 tick -> level 0.
- WALK, left held 1 tick from dir (0, 0, 0x10000) -> dir.x = -655 (0xFFFFFD71), dir.z = 65533; left+right together -> dir unchanged.
- Tick and frame_start_in coincident -> committed value is the pre-tick pose; the following frame_start_in commits the new one.
- CAMERA_POS_CLAMP_EN, POS_LIMIT=0x20000, x=0x1FF00, right held -> x saturates at 0x20000 and stays there; without the macro, x passes 0x20000.
